// File: rtl/cache_pkg.sv
// Shared types and helpers for the N-way write-through cache.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        logic [31:0] e;
        for (int i = 0; i < 4; i++) e[8*i +: 8] = {8{m[i]}};
        return e;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  m);
        logic [31:0] e;
        e = expand_mask(m);
        return (old_w & ~e) | (new_w & e);
    endfunction

    function automatic int tag_width(input int sets_log2, input int line_log2);
        return 30 - sets_log2 - line_log2;
    endfunction

    function automatic int set_lsb(input int line_log2);
        return line_log2 + 2;
    endfunction

endpackage

// File: rtl/cache_refill_seq.sv
// Line refill sequencer: issues one read per word in ascending order and
// tracks the in-order responses, pulsing o_done on the last one.
module cache_refill_seq #(
    parameter int LINE_LOG2 = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_active,
    input  logic                 i_mem_ready,
    input  logic                 i_mem_valid,
    output logic                 o_mem_ren,
    output logic [LINE_LOG2-1:0] o_issue_idx,
    output logic [LINE_LOG2-1:0] o_recv_idx,
    output logic                 o_recv_we,
    output logic                 o_done
);
    logic [LINE_LOG2:0]   issue_q, issue_d;
    logic [LINE_LOG2-1:0] recv_q, recv_d;

    // MSB of the issue counter marks "all words issued"
    always_comb begin
        o_mem_ren   = i_active & ~issue_q[LINE_LOG2];
        o_issue_idx = issue_q[LINE_LOG2-1:0];
        o_recv_idx  = recv_q;
        o_recv_we   = i_active & i_mem_valid;
        o_done      = o_recv_we & (recv_q == '1);
        issue_d     = '0;
        recv_d      = '0;
        if (i_active) begin
            issue_d = issue_q + (LINE_LOG2+1)'(o_mem_ren & i_mem_ready);
            recv_d  = o_recv_we ? recv_q + LINE_LOG2'(1) : recv_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            issue_q <= '0;
            recv_q  <= '0;
        end else begin
            issue_q <= issue_d;
            recv_q  <= recv_d;
        end
    end

endmodule

// File: rtl/cache_nway.sv
// Write-through, write-allocate N-way set-associative cache with
// round-robin/NMRU victim pointers, single-cycle flush and hit/miss counters.
//   state  | meaning
//   IDLE   | serve hits, detect misses, accept flush
//   REFILL | fetch victim line from memory
//   WRITE  | post the merged write word, waiting for mem ready
//   DONE   | one-cycle completion, read data returned
module cache_nway #(
    parameter int SETS_LOG2 = 5,
    parameter int WAYS      = 2,
    parameter int LINE_LOG2 = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,
    output logic        o_busy,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [3:0]  i_req_mask,
    input  logic [31:0] i_req_wdata,
    output logic [31:0] o_res_rdata,
    input  logic        i_flush,
    output logic [31:0] o_hit_count,
    output logic [31:0] o_miss_count
);
    import cache_pkg::*;

    localparam int TAG_W      = tag_width(SETS_LOG2, LINE_LOG2);
    localparam int LINE_WORDS = 2**LINE_LOG2;
    localparam int SETS       = 2**SETS_LOG2;
    localparam int WAY_W      = $clog2(WAYS);
    localparam int SET_LO     = set_lsb(LINE_LOG2);

    state_e              state_q, state_d;
    logic [31:0]         addr_q, wdata_q, hit_count_q, miss_count_q;
    logic [3:0]          mask_q;
    logic                is_write_q;
    logic [WAY_W-1:0]    way_q;
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAY_W-1:0]    ptr_q   [SETS];
    logic [TAG_W-1:0]    tags_q  [WAYS][SETS];
    logic [31:0]         data_q  [WAYS][SETS][LINE_WORDS];

    logic [TAG_W-1:0]     req_tag, lat_tag;
    logic [SETS_LOG2-1:0] req_set, lat_set;
    logic [LINE_LOG2-1:0] req_word, lat_widx, issue_idx, recv_idx;
    logic                 req_any, hit, recv_we, seq_done, refill_active;
    logic [WAY_W-1:0]     hit_way, vic_way;
    logic [31:0]          idle_word, lat_word, merged_idle, merged_lat, refill_addr;
    logic                 busy, idle_hit, idle_miss, idle_wstall, idle_whit_go;
    logic                 flush_go, wr_accept, done_cyc;

    assign req_any  = i_req_ren | i_req_wen;
    assign req_tag  = i_req_addr[31:32-TAG_W];
    assign req_set  = i_req_addr[SET_LO+SETS_LOG2-1:SET_LO];
    assign req_word = i_req_addr[SET_LO-1:2];
    assign lat_tag  = addr_q[31:32-TAG_W];
    assign lat_set  = addr_q[SET_LO+SETS_LOG2-1:SET_LO];
    assign lat_widx = addr_q[SET_LO-1:2];

    // Downward scan so the lowest matching / lowest invalid way wins
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_way = ptr_q[req_set];
        for (int w = WAYS-1; w >= 0; w--) begin
            if (valid_q[req_set][w] && tags_q[w][req_set] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_set][w]) vic_way = WAY_W'(w);
        end
    end

    assign idle_word   = data_q[hit_way][req_set][req_word];
    assign lat_word    = data_q[way_q][lat_set][lat_widx];
    assign merged_idle = merge_word(idle_word, i_req_wdata, i_req_mask);
    assign merged_lat  = merge_word(lat_word, wdata_q, mask_q);
    assign refill_addr = {addr_q[31:SET_LO], issue_idx, 2'b00};
    assign refill_active = (state_q == ST_REFILL);

    cache_refill_seq #(.LINE_LOG2(LINE_LOG2)) u_refill (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_active    (refill_active),
        .i_mem_ready (i_mem_ready),
        .i_mem_valid (i_mem_valid),
        .o_mem_ren   (o_mem_ren),
        .o_issue_idx (issue_idx),
        .o_recv_idx  (recv_idx),
        .o_recv_we   (recv_we),
        .o_done      (seq_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        busy         = 1'b0;
        o_mem_wen    = 1'b0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_res_rdata  = '0;
        idle_hit     = 1'b0;
        idle_miss    = 1'b0;
        idle_wstall  = 1'b0;
        idle_whit_go = 1'b0;
        flush_go     = 1'b0;
        wr_accept    = 1'b0;
        done_cyc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    idle_hit = hit;
                    if (!hit) begin
                        busy      = 1'b1;
                        idle_miss = 1'b1;
                        state_d   = ST_REFILL;
                    end else if (i_req_ren) begin
                        o_res_rdata = expand_mask(i_req_mask) & idle_word;
                    end else if (i_mem_ready) begin
                        idle_whit_go = 1'b1;
                        o_mem_wen    = 1'b1;
                        o_mem_addr   = i_req_addr;
                        o_mem_wdata  = merged_idle;
                    end else begin
                        busy        = 1'b1;
                        idle_wstall = 1'b1;
                        state_d     = ST_WRITE;
                    end
                end else begin
                    flush_go = i_flush;
                end
            end
            ST_REFILL: begin
                busy       = 1'b1;
                o_mem_addr = refill_addr;
                if (seq_done) state_d = is_write_q ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: begin
                busy        = 1'b1;
                o_mem_addr  = addr_q;
                o_mem_wdata = merged_lat;
                o_mem_wen   = i_mem_ready;
                wr_accept   = i_mem_ready;
                if (i_mem_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_cyc = 1'b1;
                if (!is_write_q) o_res_rdata = expand_mask(mask_q) & lat_word;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A CPU request held during reset must not show as a stall
    assign o_busy       = busy & i_rst_n;
    assign o_hit_count  = hit_count_q;
    assign o_miss_count = miss_count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            is_write_q   <= 1'b0;
            way_q        <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            if (idle_miss || idle_wstall) begin
                addr_q     <= i_req_addr;
                wdata_q    <= i_req_wdata;
                mask_q     <= i_req_mask;
                is_write_q <= i_req_wen;
                way_q      <= idle_miss ? vic_way : hit_way;
            end
            if (idle_miss) valid_q[req_set][vic_way] <= 1'b0;
            if (seq_done)  valid_q[lat_set][way_q]   <= 1'b1;
            if (flush_go) begin
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end
            if (idle_hit) ptr_q[req_set] <= hit_way + WAY_W'(1);
            if (done_cyc) ptr_q[lat_set] <= way_q + WAY_W'(1);
            if (idle_hit && hit_count_q != '1)   hit_count_q  <= hit_count_q + 32'd1;
            if (idle_miss && miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (recv_we)      data_q[way_q][lat_set][recv_idx]  <= i_mem_rdata;
        if (seq_done)     tags_q[way_q][lat_set]            <= lat_tag;
        if (idle_whit_go) data_q[hit_way][req_set][req_word] <= merged_idle;
        if (wr_accept)    data_q[way_q][lat_set][lat_widx]  <= merged_lat;
    end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway with a one-cycle-latency memory model.
module tb_cache_nway;

    logic        i_clk, i_rst_n, i_mem_ready, i_mem_valid;
    logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic        o_mem_ren, o_mem_wen, o_busy;
    logic [31:0] i_req_addr, i_req_wdata, o_res_rdata, o_hit_count, o_miss_count;
    logic        i_req_ren, i_req_wen, i_flush;
    logic [3:0]  i_req_mask;

    cache_nway #(.SETS_LOG2(5), .WAYS(2), .LINE_LOG2(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mem_ready(i_mem_ready),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid),
        .o_busy(o_busy), .i_req_addr(i_req_addr), .i_req_ren(i_req_ren),
        .i_req_wen(i_req_wen), .i_req_mask(i_req_mask), .i_req_wdata(i_req_wdata),
        .o_res_rdata(o_res_rdata), .i_flush(i_flush), .o_hit_count(o_hit_count),
        .o_miss_count(o_miss_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] mem [0:1023];
    logic [9:0]  rq[$];
    logic [31:0] rd_log[$];
    int          stall_left = 0;
    bit          stray_valid = 0;
    int          ren_cycles = 0, accept_cnt = 0, wen_count = 0, wen_cyc = 0;
    logic [31:0] wen_addr = '0, wen_data = '0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // Memory: always ready unless stalled, responds one cycle after acceptance
    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'hC000_0000 + 32'(k * 4);
        for (int k = 0; k < 4; k++) mem[32'h40 + k] = 32'hA0 + 32'(k);
        i_mem_ready = 1'b1;
        i_mem_valid = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            i_mem_valid = 1'b0;
            i_mem_rdata = '0;
            if (!i_rst_n) begin
                rq.delete();
            end else if (stray_valid) begin
                i_mem_valid = 1'b1;
                i_mem_rdata = 32'hDEAD_BEEF;
                stray_valid = 0;
            end else if (rq.size() > 0) begin
                i_mem_valid = 1'b1;
                i_mem_rdata = mem[rq.pop_front()];
            end
            if (stall_left > 0) begin
                i_mem_ready = 1'b0;
                stall_left--;
            end else begin
                i_mem_ready = 1'b1;
            end
            #1;
            if (o_mem_ren) ren_cycles++;
            if (o_mem_ren && i_mem_ready && i_rst_n) begin
                rq.push_back(o_mem_addr[11:2]);
                rd_log.push_back(o_mem_addr);
                accept_cnt++;
            end
            if (o_mem_wen && i_mem_ready) begin
                wen_count++;
                wen_addr = o_mem_addr;
                wen_data = o_mem_wdata;
                wen_cyc  = cyc;
                mem[o_mem_addr[11:2]] = o_mem_wdata;
            end
        end
    end

    task automatic access(input bit rd, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int bc, output int st);
        @(negedge i_clk);
        i_req_addr  = addr;
        i_req_ren   = rd;
        i_req_wen   = !rd;
        i_req_mask  = mask;
        i_req_wdata = wdata;
        st = cyc;
        bc = 0;
        #2;
        while (o_busy && bc < 100) begin
            @(negedge i_clk);
            #2;
            bc++;
        end
        checks++;
        if (bc >= 100) begin
            errors++;
            $display("FAIL access_timeout addr=%h busy_cycles=%0d limit=100", addr, bc);
        end
        rdata = o_res_rdata;
        @(negedge i_clk);
        i_req_ren = 1'b0;
        i_req_wen = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        #2;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_mem_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got=%b exp=0", o_mem_ren); end
        checks++; if (o_mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", o_mem_wen); end
        checks++; if (o_res_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", o_res_rdata); end
        checks++; if (o_hit_count !== 32'h0) begin errors++; $display("FAIL reset_hits got=%h exp=0", o_hit_count); end
        checks++; if (o_miss_count !== 32'h0) begin errors++; $display("FAIL reset_misses got=%h exp=0", o_miss_count); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_cold_read();
        logic [31:0] rd;
        int bc, st, acc0;
        rd_log.delete();
        acc0 = accept_cnt;
        access(1, 32'h100, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 6) begin errors++; $display("FAIL cold_busy_cycles got=%0d exp=6", bc); end
        checks++; if (accept_cnt - acc0 != 4) begin errors++; $display("FAIL cold_ren_count got=%0d exp=4", accept_cnt - acc0); end
        for (int i = 0; i < rd_log.size(); i++) begin
            checks++;
            if (rd_log[i] !== 32'h100 + 32'(4 * i)) begin
                errors++; $display("FAIL cold_ren_addr[%0d] got=%h exp=%h", i, rd_log[i], 32'h100 + 32'(4 * i));
            end
        end
        checks++; if (rd !== 32'hA0) begin errors++; $display("FAIL cold_rdata got=%h exp=000000a0", rd); end
        checks++; if (o_miss_count !== 32'd1) begin errors++; $display("FAIL cold_misses got=%0d exp=1", o_miss_count); end
        access(1, 32'h104, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 0) begin errors++; $display("FAIL hit_latency got=%0d exp=0", bc); end
        checks++; if (rd !== 32'hA1) begin errors++; $display("FAIL hit_rdata got=%h exp=000000a1", rd); end
        checks++; if (o_hit_count !== 32'd1) begin errors++; $display("FAIL hit_count got=%0d exp=1", o_hit_count); end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd;
        int bc, st, w0;
        w0 = wen_count;
        access(0, 32'h108, 4'b0010, 32'h0000_5500, rd, bc, st);
        checks++; if (bc != 0) begin errors++; $display("FAIL whit_busy got=%0d exp=0", bc); end
        checks++; if (wen_count - w0 != 1) begin errors++; $display("FAIL whit_wen_count got=%0d exp=1", wen_count - w0); end
        checks++; if (wen_cyc != st) begin errors++; $display("FAIL whit_wen_cycle got=%0d exp=%0d", wen_cyc, st); end
        checks++; if (wen_data !== 32'h0000_55A2) begin errors++; $display("FAIL whit_wdata got=%h exp=000055a2", wen_data); end
        checks++; if (wen_addr !== 32'h108) begin errors++; $display("FAIL whit_waddr got=%h exp=00000108", wen_addr); end
        access(1, 32'h108, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 0) begin errors++; $display("FAIL whit_readback_busy got=%0d exp=0", bc); end
        checks++; if (rd !== 32'h0000_55A2) begin errors++; $display("FAIL whit_readback got=%h exp=000055a2", rd); end
    endtask

    task automatic test_eviction();
        logic [31:0] rd;
        int bc, st;
        access(1, 32'h000, 4'hF, '0, rd, bc, st);
        access(1, 32'h200, 4'hF, '0, rd, bc, st);
        checks++; if (rd !== 32'hC000_0200) begin errors++; $display("FAIL evict_fill200 got=%h exp=c0000200", rd); end
        access(1, 32'h000, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 0) begin errors++; $display("FAIL evict_rehit0 got=%0d exp=0", bc); end
        access(1, 32'h400, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 6 || rd !== 32'hC000_0400) begin errors++; $display("FAIL evict_fill400 bc=%0d rd=%h exp bc=6 rd=c0000400", bc, rd); end
        access(1, 32'h000, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 0 || rd !== 32'hC000_0000) begin errors++; $display("FAIL evict_keep0 bc=%0d rd=%h exp bc=0 rd=c0000000", bc, rd); end
        access(1, 32'h200, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 6 || rd !== 32'hC000_0200) begin errors++; $display("FAIL evict_gone200 bc=%0d rd=%h exp bc=6 rd=c0000200", bc, rd); end
        checks++; if (o_hit_count !== 32'd5 || o_miss_count !== 32'd5) begin
            errors++; $display("FAIL evict_counts hits=%0d misses=%0d exp 5/5", o_hit_count, o_miss_count);
        end
    endtask

    task automatic test_stall_refill();
        logic [31:0] rd;
        int bc, st, acc0, rc0;
        rd_log.delete();
        acc0 = accept_cnt;
        rc0  = ren_cycles;
        stall_left = 4;
        access(1, 32'h300, 4'hF, '0, rd, bc, st);
        checks++; if (accept_cnt - acc0 != 4) begin errors++; $display("FAIL stall_ren_count got=%0d exp=4", accept_cnt - acc0); end
        checks++; if (ren_cycles - rc0 != 7) begin errors++; $display("FAIL stall_ren_cycles got=%0d exp=7", ren_cycles - rc0); end
        checks++; if (bc != 9) begin errors++; $display("FAIL stall_busy_cycles got=%0d exp=9", bc); end
        checks++; if (rd !== 32'hC000_0300) begin errors++; $display("FAIL stall_rdata got=%h exp=c0000300", rd); end
        checks++; if (rd_log.size() != 4 || rd_log[3] !== 32'h30C) begin
            errors++; $display("FAIL stall_last_addr n=%0d got=%h exp=0000030c", rd_log.size(), rd_log[rd_log.size()-1]);
        end
    endtask

    task automatic test_write_stall();
        logic [31:0] rd;
        int bc, st, w0;
        w0 = wen_count;
        stall_left = 4;
        access(0, 32'h104, 4'b1000, 32'h7700_0000, rd, bc, st);
        checks++; if (bc != 5) begin errors++; $display("FAIL wstall_busy_cycles got=%0d exp=5", bc); end
        checks++; if (wen_count - w0 != 1) begin errors++; $display("FAIL wstall_wen_count got=%0d exp=1", wen_count - w0); end
        checks++; if (wen_cyc - st != 4) begin errors++; $display("FAIL wstall_wen_cycle got=%0d exp=4", wen_cyc - st); end
        checks++; if (wen_data !== 32'h7700_00A1) begin errors++; $display("FAIL wstall_wdata got=%h exp=770000a1", wen_data); end
        access(1, 32'h104, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 0 || rd !== 32'h7700_00A1) begin errors++; $display("FAIL wstall_readback bc=%0d rd=%h exp bc=0 rd=770000a1", bc, rd); end
        w0 = wen_count;
        access(0, 32'h500, 4'b0001, 32'h0000_00EE, rd, bc, st);
        checks++; if (bc != 7) begin errors++; $display("FAIL wmiss_busy_cycles got=%0d exp=7", bc); end
        checks++; if (wen_count - w0 != 1 || wen_cyc - st != 6) begin
            errors++; $display("FAIL wmiss_wen n=%0d at=%0d exp n=1 at=6", wen_count - w0, wen_cyc - st);
        end
        checks++; if (wen_data !== 32'hC000_05EE) begin errors++; $display("FAIL wmiss_wdata got=%h exp=c00005ee", wen_data); end
        access(1, 32'h500, 4'b1001, '0, rd, bc, st);
        checks++; if (bc != 0 || rd !== 32'hC000_00EE) begin errors++; $display("FAIL wmiss_readback bc=%0d rd=%h exp bc=0 rd=c00000ee", bc, rd); end
        checks++; if (o_hit_count !== 32'd8 || o_miss_count !== 32'd7) begin
            errors++; $display("FAIL wstall_counts hits=%0d misses=%0d exp 8/7", o_hit_count, o_miss_count);
        end
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        int bc, st;
        @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        access(1, 32'h100, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 6) begin errors++; $display("FAIL flush_miss got=%0d exp=6", bc); end
        checks++; if (rd !== 32'hA0) begin errors++; $display("FAIL flush_rdata got=%h exp=000000a0", rd); end
        checks++; if (o_miss_count !== 32'd8 || o_hit_count !== 32'd8) begin
            errors++; $display("FAIL flush_counts hits=%0d misses=%0d exp 8/8", o_hit_count, o_miss_count);
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd;
        int bc, st, base, n;
        @(negedge i_clk);
        i_req_addr = 32'h600;
        i_req_ren  = 1'b1;
        i_req_mask = 4'hF;
        base = accept_cnt;
        n = 0;
        while (accept_cnt - base < 2 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        checks++; if (n >= 50) begin errors++; $display("FAIL midrst_wait accepted=%0d exp=2", accept_cnt - base); end
        i_rst_n   = 1'b0;
        i_req_ren = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        stray_valid = 1;
        repeat (2) @(negedge i_clk);
        #2;
        checks++; if (o_busy !== 1'b0 || o_mem_ren !== 1'b0) begin
            errors++; $display("FAIL midrst_idle busy=%b ren=%b exp 0/0", o_busy, o_mem_ren);
        end
        checks++; if (o_hit_count !== 32'd0 || o_miss_count !== 32'd0) begin
            errors++; $display("FAIL midrst_counts hits=%0d misses=%0d exp 0/0", o_hit_count, o_miss_count);
        end
        access(1, 32'h100, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 6 || rd !== 32'hA0) begin errors++; $display("FAIL midrst_invalid100 bc=%0d rd=%h exp bc=6 rd=000000a0", bc, rd); end
        access(1, 32'h600, 4'hF, '0, rd, bc, st);
        checks++; if (bc != 6 || rd !== 32'hC000_0600) begin errors++; $display("FAIL midrst_line600 bc=%0d rd=%h exp bc=6 rd=c0000600", bc, rd); end
        checks++; if (o_miss_count !== 32'd2) begin errors++; $display("FAIL midrst_misses got=%0d exp=2", o_miss_count); end
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_req_addr  = '0;
        i_req_ren   = 1'b0;
        i_req_wen   = 1'b0;
        i_req_mask  = '0;
        i_req_wdata = '0;
        i_flush     = 1'b0;
        test_reset();
        test_cold_read();
        test_write_hit();
        test_eviction();
        test_stall_refill();
        test_write_stall();
        test_flush();
        test_reset_mid_refill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
